// File: rtl/audio_pkg.sv
// audio_pkg: shared types and helpers for the audio capture controller.
//   state_e  - capture FSM state encoding
//   DataW    - default sample width
//   AddrW    - default sample RAM address width
//   sat_abs  - saturating magnitude of a sign-extended sample of width w
package audio_pkg;

    localparam int unsigned DataW = 16;
    localparam int unsigned AddrW = 14;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArm     = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    // |x| for a w-bit two's complement value carried sign-extended in 32 bits.
    // The most negative value has no positive twin, so it clamps to the max positive.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned w);
        logic [31:0] lim;
        logic [31:0] mag;
        lim = (32'd1 << (w - 1)) - 32'd1;
        mag = x[31] ? 32'(-x) : 32'(x);
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/audio_trig_detect.sv
// audio_trig_detect: amplitude trigger for the capture controller.
// Registers the saturating magnitude of each strobed sample and flags a hit in
// the following cycle, aligned with the registered sample.
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   sample_valid_i  - sample strobe (already qualified by the caller)
//   sample_i        - signed sample
//   level_i         - unsigned threshold on |sample|
//   hit_o           - one-cycle pulse: registered |sample| >= level_i
module audio_trig_detect
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W = DataW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic [DATA_W-1:0] level_i,
    output logic              hit_o
);

    logic              vld_q;
    logic [DATA_W-1:0] abs_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= 1'b0;
            abs_q <= '0;
        end else begin
            vld_q <= sample_valid_i;
            if (sample_valid_i) begin
                abs_q <= DATA_W'(sat_abs(32'(signed'(sample_i)), DATA_W));
            end
        end
    end

    assign hit_o = vld_q && (abs_q >= level_i);

endmodule

// File: rtl/audio_capture_ctrl.sv
// audio_capture_ctrl: sequences microphone samples into a single-port sample RAM.
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   start_i, stop_i      - single-cycle software commands
//   mode_cont_i          - 0 one-shot, 1 continuous ring capture
//   trig_en_i            - wait for amplitude trigger before capturing
//   trig_level_i         - trigger threshold on |sample|
//   len_i                - one-shot length (0 = full RAM)
//   data_mic_valid_i     - sample strobe
//   data_mic_i           - sample data
//   mem_we_o/addr/wdata  - RAM write port, write lands the cycle after a strobe
//   busy_o, armed_o      - status (ARM or CAPTURE / ARM only)
//   done_o               - one-cycle pulse on entry to DONE
//   wrapped_o            - sticky ring-wrap flag since last start
//   count_o              - samples written since start, saturating at 2^ADDR_W
module audio_capture_ctrl
    import audio_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrW,
    parameter int unsigned DATA_W = DataW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              mode_cont_i,
    input  logic              trig_en_i,
    input  logic [DATA_W-1:0] trig_level_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              data_mic_valid_i,
    input  logic [DATA_W-1:0] data_mic_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              busy_o,
    output logic              armed_o,
    output logic              done_o,
    output logic              wrapped_o,
    output logic [ADDR_W:0]   count_o
);

    localparam logic [ADDR_W:0]   CountMax = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

    state_e            state_q;
    logic              mode_cont_q;
    logic [DATA_W-1:0] level_q;
    logic [ADDR_W:0]   len_eff_q;
    logic              vld_q;
    logic [DATA_W-1:0] smp_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_last_q;
    logic [DATA_W-1:0] data_last_q;
    logic [ADDR_W:0]   count_q;
    logic              wrapped_q;
    logic              stop_pend_q;

    logic              busy;
    logic              accept;
    logic              hit;
    logic              write_en;
    logic              last_write;
    logic [ADDR_W:0]   count_inc;

    assign busy   = (state_q == StArm) || (state_q == StCapture);
    // Strobes outside ARM/CAPTURE never enter the write pipeline.
    assign accept = data_mic_valid_i && busy;

    audio_trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .sample_valid_i (accept),
        .sample_i       (data_mic_i),
        .level_i        (level_q),
        .hit_o          (hit)
    );

    // The write stage is the cycle after the strobe; in ARM the trigger hit
    // arrives in that same cycle, so the triggering sample is written on time.
    assign write_en   = vld_q && ((state_q == StCapture) || ((state_q == StArm) && hit));
    assign count_inc  = (count_q == CountMax) ? count_q : count_q + CountOne;
    assign last_write = !mode_cont_q && (count_inc == len_eff_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            mode_cont_q <= 1'b0;
            level_q     <= '0;
            len_eff_q   <= '0;
            vld_q       <= 1'b0;
            smp_q       <= '0;
            addr_q      <= '0;
            addr_last_q <= '0;
            data_last_q <= '0;
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            vld_q <= accept;
            if (accept) begin
                smp_q <= data_mic_i;
            end

            if (write_en) begin
                addr_q      <= addr_q + AddrOne;
                addr_last_q <= addr_q;
                data_last_q <= smp_q;
                count_q     <= count_inc;
                if (mode_cont_q && (&addr_q)) begin
                    wrapped_q <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    // start beats a simultaneous stop simply by not looking at stop here
                    if (start_i) begin
                        mode_cont_q <= mode_cont_i;
                        level_q     <= trig_level_i;
                        len_eff_q   <= (len_i == '0) ? CountMax : {1'b0, len_i};
                        addr_q      <= '0;
                        count_q     <= '0;
                        wrapped_q   <= 1'b0;
                        stop_pend_q <= 1'b0;
                        state_q     <= trig_en_i ? StArm : StCapture;
                    end
                end
                StArm: begin
                    if (write_en) begin
                        state_q <= (stop_i || last_write) ? StDone : StCapture;
                    end else if (stop_i) begin
                        state_q <= StIdle;
                    end
                end
                StCapture: begin
                    if (write_en) begin
                        if (stop_i || stop_pend_q || last_write) begin
                            state_q <= StDone;
                        end
                    end else if (stop_i) begin
                        // A stop alongside a strobe waits one cycle for that sample's write.
                        if (data_mic_valid_i) begin
                            stop_pend_q <= 1'b1;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Address/data hold the last written values while no write is in progress.
    assign mem_we_o    = write_en;
    assign mem_addr_o  = write_en ? addr_q : addr_last_q;
    assign mem_wdata_o = write_en ? smp_q : data_last_q;
    assign busy_o      = busy;
    assign armed_o     = (state_q == StArm);
    assign done_o      = (state_q == StDone);
    assign wrapped_o   = wrapped_q;
    assign count_o     = count_q;

endmodule
